// File: rtl/d_branch_resolve.sv
// rtl/d_branch_resolve.sv - decode-stage branch/jump resolution with registered PC redirect and jal link
// Optional statistic counters are built when D_BRANCH_STATS_EN is defined.
module d_branch_resolve #(
  parameter int DW     = 32,
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [2:0]        i_con_bop,
  input  logic [1:0]        i_con_jump,
  input  logic              i_con_aluPC4,
  input  logic [DW-1:0]     i_rs_data,
  input  logic [DW-1:0]     i_rt_data,
  input  logic              i_operand_ready,
  input  logic              i_stall_ex,
  input  logic [DW-1:0]     i_pc4,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_redirect,
  output logic [DW-1:0]     o_pc_target,
  output logic              o_flush_if,
  output logic              o_stall_d,
  output logic              o_link_valid,
  output logic [DW-1:0]     o_link_addr,
  output logic [STAT_W-1:0] o_stat_taken,
  output logic [STAT_W-1:0] o_stat_total
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state;

  logic          is_j, is_jr, is_br, is_jal;
  logic          transfer, need_rs, resolvable, resolve;
  logic          cond, take;
  logic          rs_neg, rs_zero;
  logic [DW-1:0] br_off, br_target, j_target, next_target, link_addr;

  always_comb begin
    is_j    = (i_con_jump == 2'b01);
    is_jr   = (i_con_jump == 2'b10);
    // a real jump code overrides whatever the bop field carries
    is_br   = !is_j && !is_jr && (i_con_bop != 3'b000) && (i_con_bop != 3'b111);
    is_jal  = is_j && i_con_aluPC4;
    transfer = i_valid && (is_j || is_jr || is_br);
    need_rs  = is_jr || is_br;
    resolvable = (!need_rs || i_operand_ready) && !i_stall_ex;
    resolve  = transfer && resolvable && (state != REDIRECT);

    rs_neg  = i_rs_data[DW-1];
    rs_zero = (i_rs_data == '0);
    cond = 1'b0;
    case (i_con_bop)
      3'b001:  cond = (i_rs_data == i_rt_data);
      3'b010:  cond = (i_rs_data != i_rt_data);
      3'b011:  cond = rs_neg || rs_zero;
      3'b100:  cond = !rs_neg && !rs_zero;
      3'b101:  cond = rs_neg;
      3'b110:  cond = !rs_neg;
      default: cond = 1'b0;
    endcase
    take = is_j || is_jr || (is_br && cond);

    br_off    = {{(DW-18){i_imm[15]}}, i_imm, 2'b00};
    br_target = i_pc4 + br_off;
    j_target  = {i_pc4[DW-1:DW-4], i_target, 2'b00};
    link_addr = i_pc4 + {{(DW-3){1'b0}}, 3'd4};
    next_target = br_target;
    if (is_j)
      next_target = j_target;
    else if (is_jr)
      next_target = i_rs_data;

    // the flushed instruction sitting in D during REDIRECT must not stall
    o_stall_d = !i_rst && transfer && !resolvable && (state != REDIRECT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_redirect   <= 1'b0;
      o_flush_if   <= 1'b0;
      o_link_valid <= 1'b0;
      o_pc_target  <= '0;
      o_link_addr  <= '0;
    end else begin
      o_redirect   <= 1'b0;
      o_flush_if   <= 1'b0;
      o_link_valid <= 1'b0;
      case (state)
        IDLE, WAIT_OPS: begin
          if (resolve) begin
            if (take) begin
              state       <= REDIRECT;
              o_redirect  <= 1'b1;
              o_flush_if  <= 1'b1;
              o_pc_target <= next_target;
              if (is_jal) begin
                o_link_valid <= 1'b1;
                o_link_addr  <= link_addr;
              end
            end else begin
              state <= IDLE;
            end
          end else if (transfer) begin
            state <= WAIT_OPS;
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef D_BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken_q, stat_total_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_taken_q <= '0;
      stat_total_q <= '0;
    end else if (resolve) begin
      if (!(&stat_total_q))
        stat_total_q <= stat_total_q + 1'b1;
      if (take && !(&stat_taken_q))
        stat_taken_q <= stat_taken_q + 1'b1;
    end
  end

  assign o_stat_taken = stat_taken_q;
  assign o_stat_total = stat_total_q;
`else
  assign o_stat_taken = '0;
  assign o_stat_total = '0;
`endif

endmodule

// File: doc/d_branch_resolve.md
Name: d_branch_resolve

Overview:
- Decode-stage branch/jump resolution unit. Sits directly downstream of the decode jump/branch control.
- Consumes its branch-op code, jump code and link flag, and waits for operand readiness.
- Evaluates the branch condition and computes the target.
- Issues a registered PC redirect with one-cycle fetch/decode flush, plus registered link info for jal.

Parameters:
- DW, 32, datapath/PC width (fixed 32 for MIPS; kept parameter for bench sizing)
- STAT_W, 16, width of optional statistic counters

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  instruction in D is valid
- i_con_bop  in  3  branch op: 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 000 none, 111 reserved
- i_con_jump  in  2  00 none, 01 j/jal, 10 jr, 11 reserved
- i_con_aluPC4  in  1  jal link request
- i_rs_data  in  DW  forwarded rs value
- i_rt_data  in  DW  forwarded rt value
- i_operand_ready  in  1  hazard unit: rs/rt values valid this cycle
- i_stall_ex  in  1  downstream stall
- i_pc4  in  DW  PC+4 of the instruction in D
- i_imm  in  16  branch offset
- i_target  in  26  jump index
- o_redirect  out  1  one-cycle pulse: load o_pc_target into PC
- o_pc_target  out  DW  redirect address (valid with o_redirect)
- o_flush_if  out  1  one-cycle pulse: squash IF and D wrong-path instructions
- o_stall_d  out  1  hold PC and IF/D register
- o_link_valid  out  1  one-cycle pulse: write link address to $31
- o_link_addr  out  DW  i_pc4+4 captured at resolution
- o_stat_taken  out  STAT_W  taken transfers (optional feature)
- o_stat_total  out  STAT_W  resolved transfers (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset has priority in every state, including WAIT_OPS/REDIRECT; a pending transfer is dropped.
- Transfer: i_valid and (i_con_bop in 001..110 or i_con_jump in 01,10).
  - Jump codes take priority over bop.
  - bop 111 and jump 11 are treated as no transfer.
- Operand needs:
  - j/jal: none.
  - jr, blez, bgtz, bltz, bgez: rs.
  - beq, bne: rs and rt.
  - Readiness is signalled solely by i_operand_ready.
- FSM states: IDLE, WAIT_OPS, REDIRECT.
  - IDLE, transfer, and (operands needed and !i_operand_ready, or i_stall_ex): go to WAIT_OPS; o_stall_d=1 combinationally the same cycle.
  - IDLE, transfer, resolvable (cycle N): evaluate. Taken goes to REDIRECT. Not taken stays IDLE with no outputs.
  - WAIT_OPS: o_stall_d=1. Inputs are held by the stalled IF/D register. Resolve when ready and !i_stall_ex, with the same outcome rules as IDLE.
  - REDIRECT (cycle N+1): o_redirect=1, o_flush_if=1, o_pc_target registered. Then go to IDLE. i_valid is ignored this cycle because that instruction is flushed.
- Conditions (signed 32-bit compares):
  - beq: rs==rt
  - bne: rs!=rt
  - blez: rs<=0
  - bgtz: rs>0
  - bltz: rs<0
  - bgez: rs>=0
  - j/jal/jr: always taken.
- Targets:
  - Branch: i_pc4 + (sign-extended i_imm << 2), mod 2^32 (wrap-around allowed).
  - j/jal: {i_pc4[31:28], i_target, 2'b00}.
  - jr: i_rs_data, unmodified.
- Link: jal (jump 01 and aluPC4=1) sets o_link_valid=1 in REDIRECT cycle and o_link_addr = i_pc4+4 captured at N. aluPC4 with any other code is ignored.
- Latency: resolution to redirect is exactly 1 cycle. Transfers are never closer than 2 cycles apart.
- o_pc_target and o_link_addr hold their last value when not pulsing.

Optional Feature:
- Macro: D_BRANCH_STATS_EN
- Defined:
  - o_stat_total increments on each resolution.
  - o_stat_taken increments on each taken resolution.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- beq, rs=rt=5, operands ready at N -> N+1: o_redirect=1, o_flush_if=1, o_pc_target = pc4 0x00400010 + (0xFFFE<<2 sign-ext) = 0x00400008; N+2: all pulses 0.
- bne, rs=rt=7 -> no redirect, no flush, no stall, stays IDLE.
- jal, pc4=0x1000_0004, target=0x0000040 -> N+1: target 0x10000100, o_link_valid=1, o_link_addr=0x10000008.
- jr with i_operand_ready=0 for 3 cycles, rs=0x0040_0200 -> o_stall_d=1 for 3 cycles; redirect to 0x00400200 one cycle after ready.
- bgez rs=0x8000_0000 (not taken), then bltz same rs (taken); i_rst asserted during a WAIT_OPS -> outputs 0, state IDLE next cycle, no redirect.
- With D_BRANCH_STATS_EN, STAT_W=4: 20 taken jumps -> o_stat_taken=15 (saturated), o_stat_total=15.
